// File: rtl/mbist_pkg.sv
// mbist_pkg
// Shared definitions for the March C- memory BIST controller:
//   - default data/address widths
//   - controller FSM state encoding
//   - March element codes M0..M5 and helpers describing each element
package mbist_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // March C- elements
   localparam logic [2:0] M0 = 3'd0;  // up   (w B)
   localparam logic [2:0] M1 = 3'd1;  // up   (r B,  w ~B)
   localparam logic [2:0] M2 = 3'd2;  // up   (r ~B, w B)
   localparam logic [2:0] M3 = 3'd3;  // down (r B,  w ~B)
   localparam logic [2:0] M4 = 3'd4;  // down (r ~B, w B)
   localparam logic [2:0] M5 = 3'd5;  // up   (r B)

   // Element walks addresses from N-1 down to 0
   function automatic logic elem_down(input logic [2:0] elem);
      return (elem == M3) || (elem == M4);
   endfunction

   // Element writes the inverted background
   function automatic logic elem_wr_inv(input logic [2:0] elem);
      return (elem == M1) || (elem == M3);
   endfunction

   // Element expects the inverted background on its reads
   function automatic logic elem_rd_inv(input logic [2:0] elem);
      return (elem == M2) || (elem == M4);
   endfunction

endpackage

// File: rtl/mbist_rd_checker.sv
// mbist_rd_checker
// Delays expected data / address / element of each issued read by two
// cycles to line up with the memory's read latency, compares against
// mem_rdata, and keeps the sticky fail flag, a saturating mismatch count
// and a capture of the first mismatch.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           clears fail status (new test launched)
//   rd_valid        a read is presented this cycle
//   rd_exp          expected data for that read
//   rd_addr         address of that read
//   rd_elem         March element of that read
//   rdata           memory read data (2 cycles after the read)
//   fail            sticky mismatch flag
//   fail_count      mismatch count, saturating at 255
//   fail_addr       address of first mismatch
//   fail_element    element of first mismatch
//   fail_rdata      data read at first mismatch
module mbist_rd_checker
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_exp,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [2:0]            rd_elem,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  fail,
   output logic [7:0]            fail_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_element,
   output logic [DATA_WIDTH-1:0] fail_rdata
);

   logic                  valid_s1_reg, valid_s2_reg;
   logic [DATA_WIDTH-1:0] exp_s1_reg, exp_s2_reg;
   logic [ADDR_WIDTH-1:0] addr_s1_reg, addr_s2_reg;
   logic [2:0]            elem_s1_reg, elem_s2_reg;
   logic                  mismatch;

   assign mismatch = valid_s2_reg && (rdata != exp_s2_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_s1_reg <= 1'b0;
         valid_s2_reg <= 1'b0;
         exp_s1_reg   <= '0;
         exp_s2_reg   <= '0;
         addr_s1_reg  <= '0;
         addr_s2_reg  <= '0;
         elem_s1_reg  <= '0;
         elem_s2_reg  <= '0;
         fail         <= 1'b0;
         fail_count   <= '0;
         fail_addr    <= '0;
         fail_element <= '0;
         fail_rdata   <= '0;
      end else begin
         valid_s1_reg <= rd_valid;
         valid_s2_reg <= valid_s1_reg;
         exp_s1_reg   <= rd_exp;
         exp_s2_reg   <= exp_s1_reg;
         addr_s1_reg  <= rd_addr;
         addr_s2_reg  <= addr_s1_reg;
         elem_s1_reg  <= rd_elem;
         elem_s2_reg  <= elem_s1_reg;
         if (clear) begin
            fail         <= 1'b0;
            fail_count   <= '0;
            fail_addr    <= '0;
            fail_element <= '0;
            fail_rdata   <= '0;
         end else if (mismatch) begin
            fail <= 1'b1;
            if (fail_count != 8'hFF) begin
               fail_count <= fail_count + 8'd1;
            end
            // fail is still low only for the first mismatch of the test
            if (!fail) begin
               fail_addr    <= addr_s2_reg;
               fail_element <= elem_s2_reg;
               fail_rdata   <= rdata;
            end
         end
      end
   end

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
// March C- BIST sequencer for a single-port memory with a one-cycle
// registered wdata path and two-cycle read latency.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a test (IDLE/DONE only)
//   bg_pattern      data background, sampled with start
//   mem_write_read  1 = write, 0 = read
//   mem_address     memory address
//   mem_wdata       write data, one cycle ahead of the write
//   mem_rdata       memory read data
//   busy            test in progress (RUN, DRAIN)
//   done            test complete
//   fail, fail_count, fail_addr, fail_element, fail_rdata  result status
// A start edge first loads the background and clears status (launch
// cycle), so mem_wdata already shows the new background for the memory's
// wdata register before the first M0 write.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] bg_pattern,
   output logic                  mem_write_read,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [7:0]            fail_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_element,
   output logic [DATA_WIDTH-1:0] fail_rdata
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

   state_t                state_reg, state_next;
   logic [2:0]            elem_reg, elem_next, elem_inc;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic                  phase_reg, phase_next;   // 0 = read, 1 = write (M1..M4)
   logic                  drain_reg, drain_next;
   logic                  launch_reg, launch_next;
   logic [DATA_WIDTH-1:0] bg_reg, bg_next;
   logic                  clear;
   logic                  last_addr;
   logic                  addr_done;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_exp;

   assign elem_inc  = elem_reg + 3'd1;
   assign last_addr = elem_down(elem_reg) ? (addr_reg == '0) : (addr_reg == ADDR_LAST);
   // Last operation at the current address: single-op elements always,
   // read/write elements on their write phase
   assign addr_done = (elem_reg == M0) || (elem_reg == M5) || phase_reg;

   always_comb begin
      state_next  = state_reg;
      elem_next   = elem_reg;
      addr_next   = addr_reg;
      phase_next  = phase_reg;
      drain_next  = drain_reg;
      launch_next = launch_reg;
      bg_next     = bg_reg;
      clear       = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (launch_reg) begin
               state_next  = ST_RUN;
               launch_next = 1'b0;
               elem_next   = M0;
               addr_next   = '0;
               phase_next  = 1'b0;
            end else if (start) begin
               launch_next = 1'b1;
               bg_next     = bg_pattern;
               clear       = 1'b1;
            end
         end
         ST_RUN: begin
            if (addr_done) begin
               phase_next = 1'b0;
               if (last_addr) begin
                  if (elem_reg == M5) begin
                     state_next = ST_DRAIN;
                     drain_next = 1'b0;
                  end else begin
                     elem_next = elem_inc;
                     addr_next = elem_down(elem_inc) ? ADDR_LAST : '0;
                  end
               end else if (elem_down(elem_reg)) begin
                  addr_next = addr_reg - 1'b1;
               end else begin
                  addr_next = addr_reg + 1'b1;
               end
            end else begin
               phase_next = 1'b1;
            end
         end
         ST_DRAIN: begin
            // two cycles to let the last reads reach the checker
            if (drain_reg) begin
               state_next = ST_DONE;
            end else begin
               drain_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         elem_reg   <= M0;
         addr_reg   <= '0;
         phase_reg  <= 1'b0;
         drain_reg  <= 1'b0;
         launch_reg <= 1'b0;
         bg_reg     <= '0;
      end else begin
         state_reg  <= state_next;
         elem_reg   <= elem_next;
         addr_reg   <= addr_next;
         phase_reg  <= phase_next;
         drain_reg  <= drain_next;
         launch_reg <= launch_next;
         bg_reg     <= bg_next;
      end
   end

   assign busy           = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign done           = (state_reg == ST_DONE) && !launch_reg;
   assign mem_write_read = (state_reg == ST_RUN) && ((elem_reg == M0) || phase_reg);
   assign mem_address    = addr_reg;
   // Write value of the element in progress; the memory registers it and
   // uses it for the next write. Outside RUN this is the plain background.
   assign mem_wdata      = ((state_reg == ST_RUN) && elem_wr_inv(elem_reg)) ? ~bg_reg : bg_reg;

   assign rd_valid = (state_reg == ST_RUN) && (elem_reg != M0) && !phase_reg;
   assign rd_exp   = elem_rd_inv(elem_reg) ? ~bg_reg : bg_reg;

   mbist_rd_checker #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_checker (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .rd_valid     (rd_valid),
      .rd_exp       (rd_exp),
      .rd_addr      (addr_reg),
      .rd_elem      (elem_reg),
      .rdata        (mem_rdata),
      .fail         (fail),
      .fail_count   (fail_count),
      .fail_addr    (fail_addr),
      .fail_element (fail_element),
      .fail_rdata   (fail_rdata)
   );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl: behavioural memory with stuck-at faults,
// table of fault scenarios with hand-computed results, plus directed
// sequences for held start, mid-run start pulse and mid-test reset.
module tb_mbist_march_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] bg_pattern;
   logic          mem_write_read;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          done;
   logic          fail;
   logic [7:0]    fail_count;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_element;
   logic [DW-1:0] fail_rdata;

   always #5 clk = ~clk;

   mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .bg_pattern     (bg_pattern),
      .mem_write_read (mem_write_read),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .done           (done),
      .fail           (fail),
      .fail_count     (fail_count),
      .fail_addr      (fail_addr),
      .fail_element   (fail_element),
      .fail_rdata     (fail_rdata)
   );

   // ---------------- memory model ----------------
   logic [DW-1:0] mem      [N];
   logic [DW-1:0] sa0_mask [N];
   logic [DW-1:0] sa1_mask [N];
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rd1, rd2;
   logic [DW-1:0] tb_bg;
   int            wr_cnt = 0;
   int            wr_err = 0;
   int            wr_base;

   assign mem_rdata = rd2;

   // March C- write order: M0 up B, M1 up ~B, M2 up B, M3 down ~B, M4 down B
   function automatic logic [DW-1:0] exp_wdata(input int k, input logic [DW-1:0] b);
      if (k < N) return b;
      if ((((k - N) / N) % 2) == 0) return ~b;
      return b;
   endfunction

   function automatic logic [AW-1:0] exp_waddr(input int k);
      int grp;
      int off;
      if (k < N) return AW'(k);
      grp = (k - N) / N;
      off = (k - N) % N;
      if (grp >= 2) return AW'(N - 1 - off);
      return AW'(off);
   endfunction

   always @(posedge clk) begin
      wdata_q <= mem_wdata;
      rd1     <= (mem[mem_address] & ~sa0_mask[mem_address]) | sa1_mask[mem_address];
      rd2     <= rd1;
      if (mem_write_read) begin
         mem[mem_address] <= wdata_q;
         wr_cnt           <= wr_cnt + 1;
         if ((wdata_q !== exp_wdata(wr_cnt - wr_base, tb_bg)) ||
             (mem_address !== exp_waddr(wr_cnt - wr_base)))
            wr_err <= wr_err + 1;
      end
   end

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [DW-1:0] bg;
      int            a_addr;
      logic [DW-1:0] a_sa0;
      logic [DW-1:0] a_sa1;
      int            b_addr;
      logic [DW-1:0] b_sa0;
      logic [DW-1:0] b_sa1;
      logic [DW-1:0] all_sa1;
      int            e_fail;
      int            e_count;
      int            e_addr;
      int            e_elem;
      int            e_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic set_faults(input vec_t v);
      for (int i = 0; i < N; i++) begin
         sa0_mask[i] = '0;
         sa1_mask[i] = v.all_sa1;
      end
      if (v.a_addr >= 0) begin
         sa0_mask[v.a_addr] = v.a_sa0;
         sa1_mask[v.a_addr] = v.a_sa1;
      end
      if (v.b_addr >= 0) begin
         sa0_mask[v.b_addr] = v.b_sa0;
         sa1_mask[v.b_addr] = v.b_sa1;
      end
   endtask

   // Launch one test and follow it to done. Checks status clearing on the
   // start edge, done latency, busy length and the write stream.
   task automatic run_test(input string tag, input logic [DW-1:0] bg, input bit hold,
                           input int pulse_at);
      int done_edges;
      int busy_cycles;
      int err_base;
      tb_bg      = bg;
      wr_base    = wr_cnt;
      err_base   = wr_err;
      bg_pattern = bg;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = hold;
      bg_pattern = ~bg;   // background must have been taken on the start edge
      check({tag, "_clr_done"},  32'(done), 32'd0);
      check({tag, "_clr_fail"},  32'(fail), 32'd0);
      check({tag, "_clr_count"}, 32'(fail_count), 32'd0);
      done_edges  = 0;
      busy_cycles = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (busy) busy_cycles++;
         if (done) begin
            done_edges = k;
            break;
         end
         start = hold || (k == pulse_at);
      end
      start = 1'b0;
      check({tag, "_done_edges"},  32'(done_edges), 32'd163);
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd162);
      check({tag, "_wr_count"},    32'(wr_cnt - wr_base), 32'd80);
      check({tag, "_wr_data"},     32'(wr_err - err_base), 32'd0);
      $display("test %s bg=%02h done_edges=%0d busy=%0d fail=%0b count=%0d addr=%0d elem=%0d rdata=%02h",
               tag, bg, done_edges, busy_cycles, fail, fail_count, fail_addr, fail_element, fail_rdata);
   endtask

   task automatic check_result(input string tag, input vec_t v);
      check({tag, "_fail"},       32'(fail), 32'(v.e_fail));
      check({tag, "_fail_count"}, 32'(fail_count), 32'(v.e_count));
      check({tag, "_fail_addr"},  32'(fail_addr), 32'(v.e_addr));
      check({tag, "_fail_elem"},  32'(fail_element), 32'(v.e_elem));
      check({tag, "_fail_rdata"}, 32'(fail_rdata), 32'(v.e_rdata));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   snap;
      //           bg     a_addr sa0    sa1    b_addr sa0    sa1    all    fail cnt addr elem rdata
      vecs[0] = '{8'h00, -1,    8'h00, 8'h00, -1,    8'h00, 8'h00, 8'h00, 0,   0,  0,   0,   8'h00};
      vecs[1] = '{8'h00,  5,    8'h00, 8'h02, -1,    8'h00, 8'h00, 8'h00, 1,   3,  5,   1,   8'h02};
      vecs[2] = '{8'hA5, 15,    8'h80, 8'h00, -1,    8'h00, 8'h00, 8'h00, 1,   3,  15,  1,   8'h25};
      vecs[3] = '{8'hFF,  0,    8'h01, 8'h00, -1,    8'h00, 8'h00, 8'h00, 1,   3,  0,   1,   8'hFE};
      vecs[4] = '{8'h00,  3,    8'h10, 8'h00, -1,    8'h00, 8'h00, 8'h00, 1,   2,  3,   2,   8'hEF};
      vecs[5] = '{8'h00, 12,    8'h00, 8'h80,  4,    8'h01, 8'h00, 8'h00, 1,   5,  12,  1,   8'h80};
      vecs[6] = '{8'h3C, -1,    8'h00, 8'h00, -1,    8'h00, 8'h00, 8'h01, 1,   48, 0,   1,   8'h3D};

      set_faults(vecs[0]);
      tb_bg      = '0;
      wr_base    = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      bg_pattern = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_fail",  32'(fail), 32'd0);
      check("rst_we",    32'(mem_write_read), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---------------- table-driven fault scenarios ----------------
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         set_faults(v);
         run_test($sformatf("vec%0d", i), v.bg, 1'b0, -1);
         check_result($sformatf("vec%0d", i), v);
         @(posedge clk); #1;
      end

      // ---------------- start held high through a whole test ----------------
      set_faults(vecs[0]);
      run_test("hold", 8'h5A, 1'b1, -1);
      check_result("hold", vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      check("hold_stay_done", 32'(done), 32'd1);
      check("hold_stay_idle", 32'(busy), 32'd0);

      // ---------------- start pulse mid-RUN is ignored ----------------
      set_faults(vecs[1]);
      run_test("pulse", vecs[1].bg, 1'b0, 50);
      check_result("pulse", vecs[1]);

      // ---------------- restart from DONE clears fail ----------------
      set_faults(vecs[0]);
      run_test("restart", 8'h00, 1'b0, -1);
      check_result("restart", vecs[0]);

      // ---------------- reset in the middle of RUN ----------------
      set_faults(vecs[1]);
      tb_bg      = 8'h3C;
      wr_base    = wr_cnt;
      bg_pattern = 8'h3C;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (41) @(posedge clk);
      #1;
      check("mid_busy",  32'(busy), 32'd1);
      check("mid_fail",  32'(fail), 32'd1);
      rst_n = 1'b0;
      #1;
      snap = wr_cnt;
      check("arst_busy",    32'(busy), 32'd0);
      check("arst_fail",    32'(fail), 32'd0);
      check("arst_count",   32'(fail_count), 32'd0);
      check("arst_faddr",   32'(fail_addr), 32'd0);
      check("arst_felem",   32'(fail_element), 32'd0);
      check("arst_frdata",  32'(fail_rdata), 32'd0);
      check("arst_we",      32'(mem_write_read), 32'd0);
      check("arst_addr",    32'(mem_address), 32'd0);
      check("arst_wdata",   32'(mem_wdata), 32'd0);
      @(posedge clk); #1;
      check("arst_edge_we",   32'(mem_write_read), 32'd0);
      check("arst_edge_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("arst_no_write", 32'(wr_cnt - snap), 32'd0);
      @(posedge clk); #1;
      $display("test reset_mid_run writes_during_reset=%0d", wr_cnt - snap);

      set_faults(vecs[0]);
      run_test("post_rst", 8'h00, 1'b0, -1);
      check_result("post_rst", vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: memory address width; N = 2^ADDR_WIDTH words are tested (addresses 0..N-1).
REQ-003 SHALL have these ports, one per line:
 clk  input  1  single clock, all flops on rising edge
 rst_n  input  1  asynchronous active-low reset
 start  input  1  one-cycle request to begin a test, sampled in IDLE only
 bg_pattern  input  DATA_WIDTH  data background, sampled on the start edge
 mem_write_read  output  1  1 = write, 0 = read; drives memory write_read
 mem_address  output  ADDR_WIDTH  drives memory address
 mem_wdata  output  DATA_WIDTH  drives memory wdata, one cycle ahead of the write
 mem_rdata  input  DATA_WIDTH  memory rdata, valid 2 cycles after a read is presented
 busy  output  1  test in progress
 done  output  1  test complete, held until next start
 fail  output  1  sticky: at least one read mismatch
 fail_count  output  8  mismatch count, saturating at 255
 fail_addr  output  ADDR_WIDTH  address of first mismatch
 fail_element  output  3  March element (0..5) of first mismatch
 fail_rdata  output  DATA_WIDTH  data read at first mismatch

Function
REQ-004 SHALL run March C-: M0 up(w B); M1 up(r B, w ~B); M2 up(r ~B, w B); M3 down(r B, w ~B); M4 down(r ~B, w B); M5 up(r B), where B = sampled bg_pattern.
REQ-005 SHALL present exactly one operation per cycle in RUN: M0/M5 one cycle per address; M1-M4 two cycles per address, read then write at the same address.
REQ-006 SHALL use FSM states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after the last M5 read; DRAIN lasts exactly 2 cycles; DRAIN->DONE; DONE->RUN on start.
REQ-007 SHALL keep RUN exactly 10N cycles, with no idle cycles between elements.
REQ-008 SHALL drive mem_wdata with the current element's write value from the cycle that element's first operation is presented; it SHALL equal B in IDLE and DONE, so the memory's one-cycle wdata register holds B for the first M0 write. In M5 it SHALL hold B.
REQ-009 SHALL pipeline expected data and a valid flag two stages behind every read, and SHALL compare mem_rdata against expected data when the delayed valid is set.
REQ-010 On a mismatch, SHALL set fail and increment fail_count (saturating). On the first mismatch only, SHALL capture fail_addr, fail_element and fail_rdata.
REQ-011 SHALL update fail, fail_count and the capture registers no later than the edge that asserts done. done SHALL rise exactly 10N+3 edges after the start-sampling edge.
REQ-012 SHALL ignore start while busy. start in DONE SHALL clear done, fail, fail_count and the capture registers and SHALL re-sample bg_pattern.
REQ-013 SHALL assert busy in RUN and DRAIN only.
REQ-014 SHALL make down-element addressing run from N-1 to 0 and up-element addressing from 0 to N-1, with no wrap past either end.

Reset
REQ-015 SHALL, on rst_n low at any time including mid-test, asynchronously enter IDLE and clear all outputs to 0, expected-data pipeline valids to 0 and the background register to 0.
REQ-016 SHALL leave the memory in read mode (mem_write_read = 0) during and after reset, so a reset mid-test issues no write.

Structure
REQ-017 SHALL take the state enum, element codes M0..M5 and the default widths from the shared package mbist_pkg.
REQ-018 SHALL place the compare pipeline, counter and first-fail capture in one sub-module, mbist_rd_checker.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, N=16)
REQ-019 Fault-free memory, bg 0x00, start -> done 163 edges after start; fail=0; fail_count=0; busy high for 162 cycles.
REQ-020 Addr 5 bit1 stuck-at-1, bg 0x00 -> fail=1, fail_count=3, fail_addr=5, fail_element=1, fail_rdata=0x02.
REQ-021 Addr 15 bit7 stuck-at-0, bg 0xA5 -> fail_count=3, fail_addr=15, fail_element=1, fail_rdata=0x25.
REQ-022 rst_n pulsed low at cycle 40 of RUN -> next edge state IDLE, all outputs 0, no write issued; a new start then yields the REQ-019 result.
REQ-023 start held high for the whole test, plus a pulse mid-RUN -> exactly one test of 163 edges; the pulse in DONE restarts and clears fail.
REQ-024 Write-timing check: each write's captured memory data equals the element value, including the first M0 write and the first write of each element.
